cpu_sequencer: RTL
==================

# cpu_sequencer

Multi-cycle control sequencer for the toycpu core. It owns the program counter and instruction register, and fetches instructions from a single-port unified memory. It presents each instruction to the combinational instruction decoder and gates the decoder's write enables so that register-file and memory writes happen exactly once, in the correct cycle. Data accesses (indirect LD, ST) share the same memory port as instruction fetch, so this block is also the port's sole arbiter.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ir` out 16: instruction register, drives decoder `instruction`.
- `pc` out 16: current instruction address.
- `dec_next_pc_sel` in 2: decoder nextPCSel; 01 means branch taken, any other value means sequential.
- `dec_halt` in 1: decoder halt.
- `dec_reg_we` in 1: decoder regFileWE.
- `dec_reg_src_mem` in 1: decoder regDataInSource (indirect load).
- `dec_imm` in 1: decoder immData.
- `dec_mem_we` in 1: decoder memWE.
- `dec_daddr_sel` in 1: decoder dAddrSel.
- `dec_addr` in 16: decoder addr (branch target).
- `rf_addr` in 16: register-file value used as data address.
- `rf_store_data` in 16: register-file value to store.
- `rf_we` out 1: gated register-file write enable.
- `flags_we` out 1: ALU flag register update strobe.
- `ld_data` out 16: latched memory read data for write-back.
- `mem_req` out 1: memory request, held until `mem_ack`.
- `mem_we` out 1: write qualifier for `mem_req`.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: read data, valid with `mem_ack`.
- `mem_ack` in 1: completes the current request.
- `halted` out 1: high while in HALTED.
- `retired` out 32: count of retired instructions.

## Operation
- FSM states (in the shared package): FETCH, EXEC, MEM, WB, HALTED.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`. On `mem_ack`, `ir`<=`mem_rdata` and the FSM moves to EXEC.
- **EXEC:** the decoder output is valid and depends only on `ir` and the flags.
  - `dec_halt`: go to HALTED. PC is unchanged and the instruction does not retire.
  - Otherwise `pc` <= (`dec_next_pc_sel`==01 ? `dec_addr` : `pc`+1), with 16-bit wrap (16'hFFFF+1 = 16'h0000).
  - Indirect load (`dec_reg_src_mem`) or store (`dec_mem_we`): go to MEM.
  - Otherwise `rf_we`=`dec_reg_we`, `flags_we`=`dec_reg_we & ~dec_imm`, `retired`++, and go to FETCH.
- **MEM:** `mem_req`=1, `mem_addr`=`dec_daddr_sel` ? `rf_addr` : `dec_addr`, `mem_we`=`dec_mem_we`, `mem_wdata`=`rf_store_data`.
  - On `mem_ack` for a load: `ld_data`<=`mem_rdata` and go to WB.
  - On `mem_ack` for a store: `retired`++ and go to FETCH.
- **WB:** `rf_we`=1 for one cycle, `retired`++, go to FETCH.
- **HALTED:** absorbing state; only `reset` leaves it. `mem_req`=0.
- `rf_we`, `flags_we`, and `mem_req` are combinational from state and must never be high outside the states listed above.
- `mem_ack` while `mem_req`=0 is ignored.
- `retired` wraps at 2^32.

## Timing
- Reset values:
  - state FETCH, `pc`=`RESET_PC`, `ir`=16'h0, `ld_data`=16'h0, `retired`=0.
  - All strobes low, `halted`=0.
  - `mem_req` is first asserted in the first cycle after `reset` deasserts.
- Reset asserted mid-access: `mem_req` drops in the cycle after reset is sampled, and a late `mem_ack` is ignored.
- `mem_ack` may arrive in the same cycle as `mem_req` (zero wait). Instruction cost with zero wait:
  - ALU, immediate LD, branch: 2 cycles.
  - ST: 3 cycles.
  - Indirect LD: 4 cycles.
- Each memory wait cycle adds one cycle. `mem_addr`, `mem_we`, and `mem_wdata` are stable while `mem_req` is held.
- `ir` changes only on a FETCH ack, so the decoder inputs and `dec_addr` are stable through EXEC, MEM, and WB.
- Branch condition is evaluated only in EXEC, using the flags as they stand in that cycle.

## Structure
- Shared package `toycpu_pkg` holds:
  - the state enum;
  - opcode constants (ALU 000, LDI 001, LDR 011, ST 101, BR 110, HALT 111);
  - `NEXTPC_SEQ`=2'b00 and `NEXTPC_BR`=2'b01.
- One natural sub-module: `pc_unit`, containing the PC register, next-PC mux, and reset load.
- The FSM, IR, port mux, and retire counter stay in `cpu_sequencer`.

## Test plan
- **Reset and fetch:** `RESET_PC`=16'h0010 with zero-wait memory returning an ALU op. Required: `mem_addr`=16'h0010 in the first cycle after reset; `rf_we` and `flags_we` pulse in cycle 2; `pc`=16'h0011; `retired`=1.
- **Branch:** taken branch (`dec_next_pc_sel`=01, `dec_addr`=16'h0400) → next fetch from 16'h0400. Not-taken → fetch from `pc`+1. PC 16'hFFFF sequential → 16'h0000.
- **Indirect load with wait:** `rf_addr`=16'h0123, memory acks after 3 wait cycles with 16'hBEEF. Required: `ld_data`=16'hBEEF; `rf_we` high exactly once, in WB; `flags_we` stays 0.
- **Store:** store with `rf_store_data`=16'h5A5A. Required: `mem_we`=1 with `mem_wdata`=16'h5A5A on one request; `rf_we` never high; next fetch at `pc`+1.
- **Halt:** HALT instruction → `halted`=1, `mem_req` stays 0 for 100 cycles, `retired` unchanged. `reset` then restarts fetch at `RESET_PC`.
- **Reset mid-MEM and spurious ack:** assert `reset` while in MEM → `mem_req` low the next cycle and a late ack is ignored; `mem_ack` pulses while idle leave `ir` unchanged.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// toycpu shared types: sequencer states, opcodes, next-PC selects.
// Imported by the sequencer, its PC unit, and the bench's decoder model.
package toycpu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    WB,
    HALTED
  } state_e;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] NEXTPC_SEQ = 2'b00;
  localparam logic [1:0] NEXTPC_BR  = 2'b01;

  function automatic logic needs_mem(
    input logic ld,
    input logic st
  );
    return ld | st;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Unified memory port: one request at a time,
// held until ack; ack may arrive in the request cycle.
interface cpu_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter: reset load, sequential step with
// 16-bit wrap, or branch target.
module pc_unit
  import toycpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] target_i,
  output logic [15:0] pc_o
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (adv_i) begin
      if (sel_i == NEXTPC_BR) pc_d = target_i;
      else                    pc_d = pc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/exec/mem/wb sequencer for toycpu; sole
// arbiter of the unified memory port.
module cpu_sequencer
  import toycpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] ir,
  output logic [15:0] pc,
  input  logic [1:0]  dec_next_pc_sel,
  input  logic        dec_halt,
  input  logic        dec_reg_we,
  input  logic        dec_reg_src_mem,
  input  logic        dec_imm,
  input  logic        dec_mem_we,
  input  logic        dec_daddr_sel,
  input  logic [15:0] dec_addr,
  input  logic [15:0] rf_addr,
  input  logic [15:0] rf_store_data,
  output logic        rf_we,
  output logic        flags_we,
  output logic [15:0] ld_data,
  cpu_sequencer_if.master bus,
  output logic        halted,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ld_q, ld_d;
  logic [31:0] ret_q, ret_d;
  logic        pc_adv;

  pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .adv_i    (pc_adv),
    .sel_i    (dec_next_pc_sel),
    .target_i (dec_addr),
    .pc_o     (pc)
  );

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    ld_d          = ld_q;
    ret_d         = ret_q;
    pc_adv        = 1'b0;
    rf_we         = 1'b0;
    flags_we      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = pc;
    bus.mem_wdata = 16'h0000;
    unique case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (dec_halt) begin
          state_d = HALTED;
        end else begin
          pc_adv = 1'b1;
          if (needs_mem(dec_reg_src_mem, dec_mem_we)) begin
            state_d = MEM;
          end else begin
            rf_we    = dec_reg_we;
            flags_we = dec_reg_we & ~dec_imm;
            ret_d    = ret_q + 32'd1;
            state_d  = FETCH;
          end
        end
      end
      MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = dec_mem_we;
        bus.mem_wdata = rf_store_data;
        bus.mem_addr  = dec_daddr_sel ? rf_addr : dec_addr;
        if (bus.mem_ack) begin
          if (dec_mem_we) begin
            ret_d   = ret_q + 32'd1;
            state_d = FETCH;
          end else begin
            ld_d    = bus.mem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        ret_d   = ret_q + 32'd1;
        state_d = FETCH;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    // Reset held: the port stays idle until the first post-reset cycle.
    if (reset) begin
      rf_we       = 1'b0;
      flags_we    = 1'b0;
      bus.mem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q    <= 16'h0000;
      ld_q    <= 16'h0000;
      ret_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ld_q    <= ld_d;
      ret_q   <= ret_d;
    end
  end

  assign ir      = ir_q;
  assign ld_data = ld_q;
  assign retired = ret_q;
  assign halted  = (state_q == HALTED);

endmodule
